// File: rtl/dmem_defs.sv
// Shared definitions for the data-memory responder: FSM encoding and defaults.
package dmem_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int DEPTH_DEF = 64;
  localparam int WAIT_DEF  = 2;
  localparam int CNT_W     = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, combinational read port that the
// parent samples on the access edge. Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with programmable wait states in front of a word memory.
// Misaligned requests skip the wait and respond with an error and zero data.
module dmem_responder
  import dmem_defs::*;
#(
  parameter int WAIT_CYCLES = WAIT_DEF,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    idx_q;
  logic             write_q;
  logic [31:0]      wdata_q;

  logic             accept, mis_in, access;
  logic             acc_write;
  logic [AW-1:0]    acc_idx;
  logic [31:0]      acc_wdata, mem_rdata;

  assign accept = req_valid && (state == S_IDLE);
  assign mis_in = (req_addr[1:0] != 2'b00);

  // Zero-wait accesses happen on the accept edge, so they use the live request.
  always_comb begin
    access    = 1'b0;
    acc_write = write_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    if (NO_WAIT) begin
      access    = accept && !mis_in;
      acc_write = req_write;
      acc_idx   = req_addr[AW+1:2];
      acc_wdata = req_wdata;
    end else begin
      access    = (state == S_WAIT) && (cnt == '0);
    end
  end

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (access && acc_write),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (mis_in || NO_WAIT) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == '0) state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    rsp_valid = (state == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        idx_q   <= req_addr[AW+1:2];
        write_q <= req_write;
        wdata_q <= req_wdata;
      end
      if (accept && !mis_in && !NO_WAIT)
        cnt <= CNT_W'(WAIT_CYCLES - 1);
      else if (state == S_WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
      if (accept && mis_in) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end else if (access) begin
        rsp_rdata <= acc_write ? 32'h0 : mem_rdata;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table, handshake corner sequences and random
// traffic against a word-array reference model (WAIT_CYCLES=2 and 0 instances).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata, rsp_rdata;
  logic        z_req_valid, z_req_ready, z_req_write, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [7:0]  z_req_addr;
  logic [31:0] z_req_wdata, z_rsp_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mm [64];
  bit          kn [64];

  typedef struct {
    logic        w;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request on the WAIT_CYCLES=2 instance; returns at the negedge after accept.
  task automatic send(input logic w, input logic [7:0] a, input logic [31:0] d);
    int n = 0;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Count edges from accept until rsp_valid; optionally toggle rsp_ready while busy.
  task automatic wait_rsp(input bit rnd, output int lat);
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      if (rnd) rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    rsp_ready = 1'b0;
    if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_rsp(input string tag, input int hold, input logic [31:0] exp_d,
                            input logic exp_e, input bit chk_d);
    for (int i = 0; i <= hold; i++) begin
      check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".req_ready"}, 32'(req_ready), 32'd0);
      check({tag, ".err"}, 32'(rsp_err), 32'(exp_e));
      if (chk_d) check({tag, ".rdata"}, rsp_rdata, exp_d);
      if (i < hold) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ".one_rsp"}, 32'(rsp_valid), 32'd0);
    check({tag, ".idle"}, 32'(req_ready), 32'd1);
  endtask

  task automatic txn(input string tag, input logic w, input logic [7:0] a, input logic [31:0] d,
                     input int hold, input bit rnd, input logic [31:0] exp_d,
                     input logic exp_e, input int exp_lat, input bit chk_d);
    int lat;
    send(w, a, d);
    wait_rsp(rnd, lat);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    finish_rsp(tag, hold, exp_d, exp_e, chk_d);
    if (w && a[1:0] == 2'b00) begin
      mm[a[7:2]] = d;
      kn[a[7:2]] = 1'b1;
    end
  endtask

  vec_t tbl [11];
  vec_t ztbl [4];

  initial begin
    int lat;
    foreach (kn[i]) kn[i] = 1'b0;
    rst_n = 1'b0;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
    z_req_valid = 0; z_req_write = 0; z_req_addr = '0; z_req_wdata = '0; z_rsp_ready = 0;

    #3;
    check("reset.req_ready", 32'(req_ready), 32'd1);
    check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset.rsp_rdata", rsp_rdata, 32'd0);
    check("reset.rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    tbl[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0, 3};
    tbl[1]  = '{1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3};
    tbl[2]  = '{1'b0, 8'h13, 32'h0,        32'h0,        1'b1, 1};
    tbl[3]  = '{1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3};
    tbl[4]  = '{1'b1, 8'h11, 32'h00000BAD, 32'h0,        1'b1, 1};
    tbl[5]  = '{1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3};
    tbl[6]  = '{1'b1, 8'hFC, 32'hCAFEF00D, 32'h0,        1'b0, 3};
    tbl[7]  = '{1'b0, 8'hFC, 32'h0,        32'hCAFEF00D, 1'b0, 3};
    tbl[8]  = '{1'b1, 8'h00, 32'h01234567, 32'h0,        1'b0, 3};
    tbl[9]  = '{1'b0, 8'h00, 32'h0,        32'h01234567, 1'b0, 3};
    tbl[10] = '{1'b0, 8'hFE, 32'h0,        32'h0,        1'b1, 1};
    foreach (tbl[i])
      txn($sformatf("vec%0d", i), tbl[i].w, tbl[i].addr, tbl[i].wdata, 0, 1'b0,
          tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_lat, 1'b1);

    // Response held for 5 cycles while a new request waits.
    send(1'b0, 8'h10, 32'h0);
    wait_rsp(1'b0, lat);
    check("hold.lat", 32'(lat), 32'd3);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h40; req_wdata = 32'h00000055;
    for (int i = 0; i < 5; i++) begin
      check("hold.valid", 32'(rsp_valid), 32'd1);
      check("hold.rdata", rsp_rdata, 32'hDEADBEEF);
      check("hold.err", 32'(rsp_err), 32'd0);
      check("hold.req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("hold.exit_valid", 32'(rsp_valid), 32'd0);
    check("hold.exit_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("hold.next_accepted", 32'(req_ready), 32'd0);
    wait_rsp(1'b0, lat);
    check("hold.next_lat", 32'(lat), 32'd3);
    finish_rsp("hold.next", 0, 32'h0, 1'b0, 1'b1);
    mm[16] = 32'h00000055; kn[16] = 1'b1;
    txn("hold.readback", 1'b0, 8'h40, 32'h0, 0, 1'b0, 32'h00000055, 1'b0, 3, 1'b1);

    // Reset during WAIT aborts the store.
    txn("rst.pre", 1'b1, 8'h20, 32'h11111111, 0, 1'b0, 32'h0, 1'b0, 3, 1'b1);
    send(1'b1, 8'h20, 32'h12345678);
    check("rst.in_wait", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk); @(negedge clk);
    check("rst.still_idle", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    txn("rst.readback", 1'b0, 8'h20, 32'h0, 0, 1'b0, 32'h11111111, 1'b0, 3, 1'b1);

    // Random traffic against the word-array model.
    for (int t = 0; t < 200; t++) begin
      logic       w;
      logic [7:0] a;
      logic [31:0] d, ed;
      logic       ee;
      bit         cd;
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      a = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7) << 2) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      ee = (a[1:0] != 2'b00);
      ed = (ee || w) ? 32'h0 : mm[a[7:2]];
      cd = ee || w || kn[a[7:2]];
      txn($sformatf("rnd%0d", t), w, a, d, $urandom_range(0, 3), 1'b1,
          ed, ee, ee ? 1 : 3, cd);
    end

    // Zero-wait instance.
    ztbl[0] = '{1'b1, 8'hFC, 32'hA5A5A5A5, 32'h0,        1'b0, 1};
    ztbl[1] = '{1'b0, 8'hFC, 32'h0,        32'hA5A5A5A5, 1'b0, 1};
    ztbl[2] = '{1'b0, 8'hFD, 32'h0,        32'h0,        1'b1, 1};
    ztbl[3] = '{1'b0, 8'hFC, 32'h0,        32'hA5A5A5A5, 1'b0, 1};
    foreach (ztbl[i]) begin
      string tag;
      tag = $sformatf("zw%0d", i);
      z_req_valid = 1'b1; z_req_write = ztbl[i].w;
      z_req_addr = ztbl[i].addr; z_req_wdata = ztbl[i].wdata;
      check({tag, ".req_ready"}, 32'(z_req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      z_req_valid = 1'b0;
      check({tag, ".valid"}, 32'(z_rsp_valid), 32'd1);
      check({tag, ".rdata"}, z_rsp_rdata, ztbl[i].exp_rdata);
      check({tag, ".err"}, 32'(z_rsp_err), 32'(ztbl[i].exp_err));
      z_rsp_ready = 1'b1;
      @(negedge clk);
      z_rsp_ready = 1'b0;
      check({tag, ".one_rsp"}, 32'(z_rsp_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
